// File: rtl/msk_aes_nsbox_sequencer.sv
// Round-loop control sequencer for masked AES with NSB shared Sboxes per cycle.
// Schedules KEY / DATA / DRAIN phases per round and the I/O handshakes; touches no shares.
module msk_aes_nsbox_sequencer #(
  parameter int NSB    = 4,
  parameter int SB_LAT = 4,
  localparam int CPR   = 16 / NSB,
  localparam int GW    = (CPR > 1) ? $clog2(CPR) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  output logic          in_ready,
  input  logic          mode_256,
  input  logic          mode_192,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          global_init,
  output logic          sbox_valid_in,
  output logic          feed_sb_key,
  output logic [GW-1:0] grp_idx,
  output logic [3:0]    round_idx,
  output logic          last_round,
  output logic          in_ready_rnd
);

  localparam int DW = (SB_LAT > 1) ? $clog2(SB_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEY   = 3'd1,
    S_DATA  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grp;
  logic [DW-1:0]   r_drn;
  logic [3:0]      r_round;
  logic [3:0]      r_nr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_grp   <= '0;
      r_drn   <= '0;
      r_round <= '0;
      r_nr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_nr    <= mode_256 ? 4'd14 : (mode_192 ? 4'd12 : 4'd10);
            r_round <= 4'd1;
            r_grp   <= '0;
            r_drn   <= '0;
            r_state <= S_KEY;
          end
        end
        S_KEY: r_state <= S_DATA;
        S_DATA: begin
          if (r_grp == GW'(CPR - 1)) begin
            r_grp   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_grp <= r_grp + 1'b1;
          end
        end
        S_DRAIN: begin
          // Wait out the Sbox pipeline before the next round's key byte enters it.
          if (r_drn == DW'(SB_LAT - 1)) begin
            r_drn <= '0;
            if (r_round < r_nr) begin
              r_round <= r_round + 4'd1;
              r_state <= S_KEY;
            end else begin
              r_round <= 4'd0;
              r_state <= S_DONE;
            end
          end else begin
            r_drn <= r_drn + 1'b1;
          end
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic w_idle, w_key, w_data, w_run;
  assign w_idle = (r_state == S_IDLE);
  assign w_key  = (r_state == S_KEY);
  assign w_data = (r_state == S_DATA);
  assign w_run  = w_key | w_data | (r_state == S_DRAIN);

  // Every flag is qualified by rst so nothing is asserted during reset, not even in_ready.
  assign in_ready      = rst & w_idle;
  assign global_init   = rst & w_idle & valid_in;
  assign out_valid     = rst & (r_state == S_DONE);
  assign busy          = rst & ~w_idle;
  assign sbox_valid_in = rst & (w_key | w_data);
  assign feed_sb_key   = rst & w_key;
  assign grp_idx       = rst ? r_grp : '0;
  assign round_idx     = rst ? r_round : 4'd0;
  assign last_round    = rst & w_run & (r_round == r_nr);
  assign in_ready_rnd  = rst & w_run;

endmodule

// File: tb/tb_msk_aes_nsbox_sequencer.sv
// Bench for msk_aes_nsbox_sequencer: three configurations (NSB 4/16/8) against a
// schedule model computed from the cycle offset since accept.
module tb_msk_aes_nsbox_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] valid_in, mode_256, mode_192, out_ready;
  logic [2:0] in_ready, out_valid, busy, global_init, sbox_valid_in;
  logic [2:0] feed_sb_key, last_round, in_ready_rnd;
  logic [3:0] round_v [3];
  logic [1:0] g0;
  logic [0:0] g1, g2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: phase 0 idle, 1 running (k = cycles since accept), 2 done
  int m_ph [3] = '{0, 0, 0};
  int m_k  [3] = '{0, 0, 0};
  int m_nr [3] = '{0, 0, 0};

  msk_aes_nsbox_sequencer #(.NSB(4), .SB_LAT(4)) u0 (
    .clk(clk), .rst(rst), .valid_in(valid_in[0]), .in_ready(in_ready[0]),
    .mode_256(mode_256[0]), .mode_192(mode_192[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .busy(busy[0]), .global_init(global_init[0]),
    .sbox_valid_in(sbox_valid_in[0]), .feed_sb_key(feed_sb_key[0]), .grp_idx(g0),
    .round_idx(round_v[0]), .last_round(last_round[0]), .in_ready_rnd(in_ready_rnd[0]));

  msk_aes_nsbox_sequencer #(.NSB(16), .SB_LAT(4)) u1 (
    .clk(clk), .rst(rst), .valid_in(valid_in[1]), .in_ready(in_ready[1]),
    .mode_256(mode_256[1]), .mode_192(mode_192[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .busy(busy[1]), .global_init(global_init[1]),
    .sbox_valid_in(sbox_valid_in[1]), .feed_sb_key(feed_sb_key[1]), .grp_idx(g1),
    .round_idx(round_v[1]), .last_round(last_round[1]), .in_ready_rnd(in_ready_rnd[1]));

  msk_aes_nsbox_sequencer #(.NSB(8), .SB_LAT(4)) u2 (
    .clk(clk), .rst(rst), .valid_in(valid_in[2]), .in_ready(in_ready[2]),
    .mode_256(mode_256[2]), .mode_192(mode_192[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .busy(busy[2]), .global_init(global_init[2]),
    .sbox_valid_in(sbox_valid_in[2]), .feed_sb_key(feed_sb_key[2]), .grp_idx(g2),
    .round_idx(round_v[2]), .last_round(last_round[2]), .in_ready_rnd(in_ready_rnd[2]));

  function automatic int cpr_of(int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 2);
  endfunction

  function automatic int per_of(int i);
    return 1 + cpr_of(i) + 4;
  endfunction

  function automatic int nr_of(logic m256, logic m192);
    return m256 ? 14 : (m192 ? 12 : 10);
  endfunction

  task automatic chk(string tag, int i, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d cyc=%0d obs=%0d exp=%0d", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic check_inst(int i);
    int e_ir, e_gi, e_ov, e_bz, e_sv, e_fk, e_grp, e_rd, e_lr, e_rnd, p, r, grp_obs;
    e_ir = 0; e_gi = 0; e_ov = 0; e_bz = 0; e_sv = 0; e_fk = 0;
    e_grp = 0; e_rd = 0; e_lr = 0; e_rnd = 0;
    if (rst) begin
      case (m_ph[i])
        0: begin e_ir = 1; e_gi = int'(valid_in[i]); end
        1: begin
          r = (m_k[i] - 1) / per_of(i) + 1;
          p = (m_k[i] - 1) % per_of(i);
          e_bz  = 1;
          e_sv  = (p <= cpr_of(i)) ? 1 : 0;
          e_fk  = (p == 0) ? 1 : 0;
          e_grp = (p >= 1 && p <= cpr_of(i)) ? p - 1 : 0;
          e_rd  = r;
          e_lr  = (r == m_nr[i]) ? 1 : 0;
          e_rnd = 1;
        end
        default: begin e_ov = 1; e_bz = 1; end
      endcase
    end
    grp_obs = (i == 0) ? int'(g0) : ((i == 1) ? int'(g1) : int'(g2));
    chk("in_ready", i, in_ready[i], e_ir);
    chk("global_init", i, global_init[i], e_gi);
    chk("out_valid", i, out_valid[i], e_ov);
    chk("busy", i, busy[i], e_bz);
    chk("sbox_valid_in", i, sbox_valid_in[i], e_sv);
    chk("feed_sb_key", i, feed_sb_key[i], e_fk);
    chk("grp_idx", i, grp_obs, e_grp);
    chk("round_idx", i, round_v[i], e_rd);
    chk("last_round", i, last_round[i], e_lr);
    chk("in_ready_rnd", i, in_ready_rnd[i], e_rnd);
  endtask

  // Check the current cycle, then advance one clock and update the model.
  task automatic tick;
    #1;
    for (int i = 0; i < 3; i++) check_inst(i);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst) m_ph[i] = 0;
      else case (m_ph[i])
        0: if (valid_in[i]) begin
             m_ph[i] = 1; m_k[i] = 1; m_nr[i] = nr_of(mode_256[i], mode_192[i]);
           end
        1: if (m_k[i] == m_nr[i] * per_of(i)) m_ph[i] = 2; else m_k[i]++;
        default: if (out_ready[i]) m_ph[i] = 0;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_op(int i, logic m256, logic m192, int hold);
    int t, guard;
    valid_in[i] = 1'b1; mode_256[i] = m256; mode_192[i] = m192; out_ready[i] = 1'b0;
    t = cyc;
    tick();
    guard = 0;
    while (!out_valid[i] && guard < 2000) begin
      valid_in[i] = 1'($urandom); mode_256[i] = 1'($urandom); mode_192[i] = 1'($urandom);
      tick();
      guard++;
    end
    chk("latency", i, cyc - t, 1 + nr_of(m256, m192) * per_of(i));
    valid_in[i] = 1'b1;
    repeat (hold) tick();
    chk("done_hold", i, out_valid[i], 1);
    out_ready[i] = 1'b1;
    tick();
    chk("back_idle", i, in_ready[i], 1);
    out_ready[i] = 1'b0; valid_in[i] = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    valid_in = '0; mode_256 = '0; mode_192 = '0; out_ready = '0;
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    run_op(0, 1'b0, 1'b0, 20);
    run_op(1, 1'b0, 1'b1, 0);
    run_op(2, 1'b1, 1'b1, 3);
    for (int n = 0; n < 6; n++)
      run_op(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), int'($urandom_range(0, 5)));

    // reset in the DATA phase of round 5, then a clean run
    valid_in[0] = 1'b1; mode_256[0] = 1'b0; mode_192[0] = 1'b0;
    tick();
    valid_in[0] = 1'b0;
    guard = 0;
    while (!(m_ph[0] == 1 && m_k[0] == 4 * per_of(0) + 3) && guard < 500) begin
      tick();
      guard++;
    end
    chk("round5_reached", 0, round_v[0], 5);
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", 0, out_valid[0], 0);
    rst = 1'b1;
    tick();
    chk("rst_then_idle", 0, in_ready[0], 1);
    run_op(0, 1'b0, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
